alu_op_sequencer: RTL and testbench

//  Upstream issue stage for the combinational alu: buffers operation requests in a small FIFO,

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu.sv | 91 +++++++++
 rtl/alu_op_fifo.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the alu issue path: opcode enum, request record, opcode legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_pkg;

    // Request records are sized for the widest supported operand. Users keep the low SIZE bits.
    localparam int ALU_MAX_SIZE = 16;

    typedef enum logic [3:0] {
        CMD_AND   = 4'd0,
        CMD_OR    = 4'd1,
        CMD_XOR   = 4'd2,
        CMD_NOT   = 4'd3,
        CMD_ADD   = 4'd4,
        CMD_SADD  = 4'd5,
        CMD_SUB   = 4'd6,
        CMD_SSUB  = 4'd7,
        CMD_MUL   = 4'd8,
        CMD_SMUL  = 4'd9,
        CMD_CMP   = 4'd10,
        CMD_SCMP  = 4'd11,
        CMD_SHIFT = 4'd12
    } alu_cmd_e;

    localparam logic [3:0] CMD_LAST = 4'd12;

    // cmd is kept as raw bits so that illegal opcodes 13..15 can be carried to the output.
    typedef struct packed {
        logic [3:0]              cmd;
        logic [ALU_MAX_SIZE-1:0] a;
        logic [ALU_MAX_SIZE-1:0] b;
        logic                    chain;
    } alu_req_t;

    function automatic logic is_illegal(input logic [3:0] cmd);
        return cmd > CMD_LAST;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational alu: bitwise, add/sub, multiply, compare and one-bit shift on SIZE-bit operands.
// Latency: 0 cycles. Outputs are zero while enable is low.
// Backpressure: none, because the alu is purely combinational.
module alu import alu_pkg::*; #(
    parameter int SIZE = 2
) (
    input  logic              enable,
    input  logic [3:0]        command,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] result,
    output logic              overflow
);

    localparam int MSB = SIZE - 1;

    logic [SIZE:0]     sum;
    logic [SIZE:0]     diff;
    logic [2*SIZE-1:0] prod_u;
    logic [2*SIZE-1:0] prod_s;
    logic [SIZE-1:0]   lo;
    logic              wide;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};
    assign prod_u = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    // Sign-extended operands: the low 2*SIZE bits of the product are the signed product.
    assign prod_s = {{SIZE{a[MSB]}}, a} * {{SIZE{b[MSB]}}, b};

    // Decode the opcode. Narrow ops build lo, which is then zero-extended. Multiplies use the full width.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        lo       = '0;
        wide     = 1'b0;
        if (enable) begin
            case (command)
                CMD_AND:  lo = a & b;
                CMD_OR:   lo = a | b;
                CMD_XOR:  lo = a ^ b;
                CMD_NOT:  lo = ~a;
                CMD_ADD: begin
                    lo       = sum[MSB:0];
                    overflow = sum[SIZE];
                end
                CMD_SADD: begin
                    lo       = sum[MSB:0];
                    overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                end
                CMD_SUB: begin
                    lo       = diff[MSB:0];
                    overflow = diff[SIZE];
                end
                CMD_SSUB: begin
                    lo       = diff[MSB:0];
                    overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
                end
                CMD_MUL: begin
                    wide   = 1'b1;
                    result = prod_u;
                end
                CMD_SMUL: begin
                    wide   = 1'b1;
                    result = prod_s;
                end
                CMD_CMP: begin
                    lo[1] = a < b;
                    lo[0] = a == b;
                end
                CMD_SCMP: begin
                    lo[1] = $signed(a) < $signed(b);
                    lo[0] = a == b;
                end
                CMD_SHIFT: begin
                    // b[0] selects the direction (1 = right). b[1] selects an arithmetic right shift.
                    if (b[0]) begin
                        lo = {b[1] & a[MSB], a[MSB:1]};
                    end else begin
                        lo       = {a[MSB-1:0], 1'b0};
                        overflow = a[MSB];
                    end
                end
                default: lo = '0;
            endcase
            if (!wide) begin
                result = {{SIZE{1'b0}}, lo};
            end
        end
    end

endmodule

// File: rtl/alu_op_fifo.sv
// Synchronous FIFO of alu_req_t with full/empty/count. The head entry is visible combinationally.
// Latency: a pushed entry is at the head on the cycle after the push if the FIFO was empty.
// Backpressure: a push while full is dropped, even if a pop happens in the same cycle. A pop while empty is ignored.
module alu_op_fifo import alu_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  alu_req_t               push_dat,
    input  logic                   pop,
    output alu_req_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = DEPTH;

    alu_req_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    // Storage write. Contents need no reset because the count masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage: queues alu requests, issues one per cycle into the alu and registers the result into a valid/ready slot.
// Latency: 2 cycles from accept to out_valid; throughput 1 op/cycle. ALU_SEQ_CHAIN_EN enables result chaining.
// Backpressure: in_ready drops when the FIFO is full. The slot holds while out_ready is low, which stalls issue.
module alu_op_sequencer import alu_pkg::*; #(
    parameter int SIZE       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_command,
    input  logic [SIZE-1:0]   in_a,
    input  logic [SIZE-1:0]   in_b,
    input  logic              in_chain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] out_result,
    output logic              out_overflow,
    output logic              out_illegal,
    output logic              sticky_overflow,
    input  logic              clear_sticky
);

    alu_req_t                     push_req;
    alu_req_t                     head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         issue;
    logic                         head_illegal;
    logic                         alu_en;
    logic [SIZE-1:0]              alu_a;
    logic [2*SIZE-1:0]            alu_result;
    logic                         alu_overflow;
    logic                         unused_bits;

    // Pack the incoming request. Operand bits above SIZE stay zero.
    always_comb begin
        push_req                = '0;
        push_req.cmd            = in_command;
        push_req.a[SIZE-1:0]    = in_a;
        push_req.b[SIZE-1:0]    = in_b;
`ifdef ALU_SEQ_CHAIN_EN
        push_req.chain          = in_chain;
`endif
    end

    alu_op_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat (push_req),
        .pop      (issue),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign in_ready     = !fifo_full;
    assign issue        = !fifo_empty && (!out_valid || out_ready);
    assign head_illegal = is_illegal(head.cmd);
    assign alu_en       = issue && !head_illegal;

`ifdef ALU_SEQ_CHAIN_EN
    logic [SIZE-1:0] chain_q;

    // Remember the low half of every issued result. Illegal ops leave zero behind.
    always_ff @(posedge clk) begin
        if (reset)      chain_q <= '0;
        else if (issue) chain_q <= head_illegal ? '0 : alu_result[SIZE-1:0];
    end

    assign alu_a = head.chain ? chain_q : head.a[SIZE-1:0];
`else
    assign alu_a = head.a[SIZE-1:0];
`endif

    alu #(
        .SIZE (SIZE)
    ) u_alu (
        .enable   (alu_en),
        .command  (head.cmd),
        .a        (alu_a),
        .b        (head.b[SIZE-1:0]),
        .result   (alu_result),
        .overflow (alu_overflow)
    );

    // Output slot: refill on issue (this also covers a same-cycle drain), otherwise empty it once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_result   <= head_illegal ? '0 : alu_result;
            out_overflow <= head_illegal ? 1'b0 : alu_overflow;
            out_illegal  <= head_illegal;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Sticky overflow is set when an overflowing result is consumed. A clear takes priority.
    always_ff @(posedge clk) begin
        if (reset)                                          sticky_overflow <= 1'b0;
        else if (clear_sticky)                              sticky_overflow <= 1'b0;
        else if (out_valid && out_ready && out_overflow)    sticky_overflow <= 1'b1;
    end

    // Operand bits above SIZE, the FIFO count and the chain flag (in the default build) have no consumer here.
    assign unused_bits = ^{head, fifo_count, in_chain};

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer at SIZE=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
// Chaining expectations depend on ALU_SEQ_CHAIN_EN.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int SIZE = 4;
    localparam int NV   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_command = '0;
    logic [SIZE-1:0]   in_a = '0;
    logic [SIZE-1:0]   in_b = '0;
    logic              in_chain = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*SIZE-1:0] out_result;
    logic              out_overflow;
    logic              out_illegal;
    logic              sticky_overflow;
    logic              clear_sticky = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Streamed vectors: cmd, a, b, expected result, expected overflow.
    logic [3:0] v_cmd [NV] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd5, 4'd7, 4'd9,
                               4'd8, 4'd10, 4'd11, 4'd10, 4'd12, 4'd12, 4'd12, 4'd6};
    logic [3:0] v_a   [NV] = '{4'hC, 4'hC, 4'hC, 4'h5, 4'h3, 4'h7, 4'h8, 4'hF,
                               4'hC, 4'h3, 4'hF, 4'h5, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [3:0] v_b   [NV] = '{4'hA, 4'hA, 4'hA, 4'h0, 4'h5, 4'h1, 4'h1, 4'h2,
                               4'hD, 4'h5, 4'h1, 4'h5, 4'h0, 4'h3, 4'h1, 4'h4};
    logic [7:0] v_res [NV] = '{8'h08, 8'h0E, 8'h06, 8'h0A, 8'h0E, 8'h08, 8'h07, 8'hFE,
                               8'h9C, 8'h02, 8'h02, 8'h01, 8'h02, 8'h0C, 8'h04, 8'h05};
    logic       v_ovf [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .SIZE       (SIZE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_command      (in_command),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_chain        (in_chain),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_overflow    (out_overflow),
        .out_illegal     (out_illegal),
        .sticky_overflow (sticky_overflow),
        .clear_sticky    (clear_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [3:0] a, input logic [3:0] b,
                         input logic ch);
        in_valid   = 1'b1;
        in_command = cmd;
        in_a       = a;
        in_b       = b;
        in_chain   = ch;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(out_result), 32'd0);
        chk("rst_ovf", 32'(out_overflow), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_sticky", 32'(sticky_overflow), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;

        // Basic ADD with 2-cycle latency
        drive(CMD_ADD, 4'd3, 4'd4, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("add_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", 32'(out_result), 32'd7);
        chk("add_ovf", 32'(out_overflow), 32'd0);
        chk("add_illegal", 32'(out_illegal), 32'd0);
        tick();
        chk("add_drained", 32'(out_valid), 32'd0);

        // Overflow and the sticky flag
        drive(CMD_ADD, 4'd15, 4'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf_result", 32'(out_result), 32'd0);
        chk("ovf_flag", 32'(out_overflow), 32'd1);
        chk("ovf_sticky_pre", 32'(sticky_overflow), 32'd0);
        tick();
        chk("ovf_sticky_set", 32'(sticky_overflow), 32'd1);
        drive(CMD_ADD, 4'd15, 4'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf2_flag", 32'(out_overflow), 32'd1);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        chk("clear_wins", 32'(sticky_overflow), 32'd0);
        tick();
        chk("clear_stays", 32'(sticky_overflow), 32'd0);

        // Illegal opcode followed by a full-width multiply
        drive(4'd14, 4'd5, 4'd3, 1'b0);
        tick();
        drive(CMD_MUL, 4'd15, 4'd15, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ill_illegal", 32'(out_illegal), 32'd1);
        chk("ill_result", 32'(out_result), 32'd0);
        chk("ill_ovf", 32'(out_overflow), 32'd0);
        tick();
        chk("mul_result", 32'(out_result), 32'd225);
        chk("mul_illegal", 32'(out_illegal), 32'd0);
        chk("mul_ovf", 32'(out_overflow), 32'd0);
        tick();
        chk("mul_drained", 32'(out_valid), 32'd0);

        // Back-to-back stream of every opcode class, one result per cycle
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(v_cmd[i], v_a[i], v_b[i], 1'b0);
            else        in_valid = 1'b0;
            tick();
            if (i == 0) begin
                chk("stream_first_valid", 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d_result", i - 1), 32'(out_result), 32'(v_res[i - 1]));
                chk($sformatf("stream%0d_ovf", i - 1), 32'(out_overflow), 32'(v_ovf[i - 1]));
            end
        end
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Fill under backpressure, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(CMD_ADD, 4'(i), 4'd1, 1'b0);
            tick();
            if (i == 4) chk("fill4_in_ready", 32'(in_ready), 32'd1);
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_slot_valid", 32'(out_valid), 32'd1);
        chk("full_slot_result", 32'(out_result), 32'd2);
        drive(CMD_ADD, 4'd9, 4'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("full_reject_ready", 32'(in_ready), 32'd0);
        chk("full_hold_result", 32'(out_result), 32'd2);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_result", k), 32'(out_result), 32'(k + 1));
            if (k == 2) chk("drain_in_ready", 32'(in_ready), 32'd1);
        end
        tick();
        chk("drain_no_dup", 32'(out_valid), 32'd0);

        // Reset while the FIFO is partly full and the slot is held
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(CMD_ADD, 4'(i), 4'd2, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_held", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_result", 32'(out_result), 32'd0);
        chk("mid_rst_sticky", 32'(sticky_overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", i), 32'(out_valid), 32'd0);
        end

        // Chaining: ADD 2+3, then a chained ADD with b=4 and an in-entry a of 1
        drive(CMD_ADD, 4'd2, 4'd3, 1'b0);
        tick();
        drive(CMD_ADD, 4'd1, 4'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        in_chain = 1'b0;
        chk("chain_first", 32'(out_result), 32'd5);
        tick();
`ifdef ALU_SEQ_CHAIN_EN
        chk("chain_second", 32'(out_result), 32'd9);
`else
        chk("chain_ignored", 32'(out_result), 32'd5);
`endif
        tick();
        chk("chain_drained", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
